// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serialising unified RAM controller.
// Length codes, FSM state encoding, owner flag and byte-lane helpers.
package mem_ctrl_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Length code 11 is deliberately folded into the word case.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [2:0] idx);
        return 8'(w >> {idx, 3'b000});
    endfunction

    function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [2:0] idx);
        return {24'b0, b} << {idx, 3'b000};
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Unified byte-wide RAM port owner: arbitrates IF fetches against MEM loads/stores
// and serialises each access into little-endian byte transfers.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              busy_o,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rw,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_t            state_reg;
    owner_t            owner_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [31:0]       wdata_reg;
    logic [2:0]        n_reg;
    logic [2:0]        cnt_reg;
    logic [31:0]       asm_reg;

    logic [2:0]        cnt_next;
    logic [2:0]        cnt_prev;
    logic [ADDR_W-1:0] addr_next;

    assign cnt_next  = cnt_reg + 3'd1;
    assign cnt_prev  = cnt_reg - 3'd1;
    assign addr_next = base_reg + ADDR_W'(cnt_next);

    // All RAM-side outputs are registered, so each transition also sets up the
    // address/data for the cycle that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_IF;
            base_reg  <= '0;
            wdata_reg <= '0;
            n_reg     <= '0;
            cnt_reg   <= '0;
            asm_reg   <= '0;
            if_done   <= 1'b0;
            if_inst   <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
            busy_o    <= 1'b0;
            ram_addr  <= '0;
            ram_rw    <= 1'b0;
            ram_dout  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    asm_reg <= '0;
                    if (mem_req) begin
                        state_reg <= mem_we ? ST_WRITE : ST_READ;
                        owner_reg <= OWN_MEM;
                        base_reg  <= mem_addr;
                        wdata_reg <= mem_wdata;
                        n_reg     <= len_bytes(mem_len);
                        busy_o    <= 1'b1;
                        ram_addr  <= mem_addr;
                        ram_rw    <= mem_we;
                        ram_dout  <= mem_we ? mem_wdata[7:0] : 8'h00;
                    end else if (if_req && !if_cancel) begin
                        state_reg <= ST_READ;
                        owner_reg <= OWN_IF;
                        base_reg  <= if_addr;
                        wdata_reg <= '0;
                        n_reg     <= 3'd4;
                        busy_o    <= 1'b1;
                        ram_addr  <= if_addr;
                        ram_rw    <= 1'b0;
                        ram_dout  <= 8'h00;
                    end
                end

                ST_READ: begin
                    if (owner_reg == OWN_IF && if_cancel) begin
                        state_reg <= ST_IDLE;
                        busy_o    <= 1'b0;
                        cnt_reg   <= '0;
                        asm_reg   <= '0;
                        ram_addr  <= '0;
                    end else if (cnt_reg == n_reg) begin
                        // Last byte arrives this cycle; merge it straight into the result.
                        state_reg <= ST_DONE;
                        cnt_reg   <= '0;
                        ram_addr  <= '0;
                        if (owner_reg == OWN_IF) begin
                            if_done <= 1'b1;
                            if_inst <= asm_reg | place_byte(ram_din, cnt_prev);
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= asm_reg | place_byte(ram_din, cnt_prev);
                        end
                    end else begin
                        cnt_reg  <= cnt_next;
                        ram_addr <= (cnt_next == n_reg) ? '0 : addr_next;
                        if (cnt_reg != 3'd0) begin
                            asm_reg <= asm_reg | place_byte(ram_din, cnt_prev);
                        end
                    end
                end

                ST_WRITE: begin
                    if (cnt_reg == n_reg - 3'd1) begin
                        state_reg <= ST_DONE;
                        cnt_reg   <= '0;
                        mem_done  <= 1'b1;
                        ram_addr  <= '0;
                        ram_rw    <= 1'b0;
                        ram_dout  <= 8'h00;
                    end else begin
                        cnt_reg  <= cnt_next;
                        ram_addr <= addr_next;
                        ram_dout <= byte_of(wdata_reg, cnt_next);
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    if_done   <= 1'b0;
                    mem_done  <= 1'b0;
                    busy_o    <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule
